// File: rtl/ballot_poller.sv
// Ballot poller: offers a captured ballot code to each voter in turn, collects
// yes/no/spoiled responses, records abstentions on timeout, and holds the tallies.
module ballot_poller #(
    parameter int unsigned NUM_VOTERS = 4,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned TIMEOUT    = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          io_start,
    input  logic [1:0]                    io_ballot_code,
    output logic                          io_ballot_valid,
    input  logic                          io_ballot_ready,
    output logic [$clog2(NUM_VOTERS)-1:0] io_ballot_id,
    output logic [1:0]                    io_ballot_data,
    input  logic                          io_vote_valid,
    input  logic [1:0]                    io_vote_data,
    output logic                          io_vote_ready,
    output logic                          io_busy,
    output logic                          io_done,
    output logic [CNT_W-1:0]              io_yes_count,
    output logic [CNT_W-1:0]              io_no_count,
    output logic [CNT_W-1:0]              io_spoiled_count,
    output logic [CNT_W-1:0]              io_abstain_count
);

    localparam int unsigned ID_W  = $clog2(NUM_VOTERS);
    localparam int unsigned TMR_W = $clog2(TIMEOUT);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [ID_W-1:0]  idx_q, idx_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [1:0]       code_q, code_d;
    logic [CNT_W-1:0] yes_q, yes_d;
    logic [CNT_W-1:0] no_q, no_d;
    logic [CNT_W-1:0] sp_q, sp_d;
    logic [CNT_W-1:0] ab_q, ab_d;
    logic             advance;

    logic ballot_valid_q, vote_ready_q, busy_q, done_q;

    // Tallies stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        sat_inc = (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    // Next-state and tally update.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tmr_d   = tmr_q;
        code_d  = code_q;
        yes_d   = yes_q;
        no_d    = no_q;
        sp_d    = sp_q;
        ab_d    = ab_q;
        advance = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (io_start) begin
                    state_d = S_ISSUE;
                    idx_d   = '0;
                    tmr_d   = '0;
                    code_d  = io_ballot_code;
                    yes_d   = '0;
                    no_d    = '0;
                    sp_d    = '0;
                    ab_d    = '0;
                end
            end
            S_ISSUE: begin
                if (io_ballot_ready) begin
                    state_d = S_WAIT;
                    tmr_d   = '0;
                end
            end
            S_WAIT: begin
                // A vote arriving on the timeout cycle wins over the abstention.
                if (io_vote_valid) begin
                    case (io_vote_data)
                        2'd1:    yes_d = sat_inc(yes_q);
                        2'd0:    no_d  = sat_inc(no_q);
                        default: sp_d  = sat_inc(sp_q);
                    endcase
                    advance = 1'b1;
                end else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
                    ab_d    = sat_inc(ab_q);
                    advance = 1'b1;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (advance) begin
            if (idx_q == ID_W'(NUM_VOTERS - 1)) begin
                state_d = S_DONE;
            end else begin
                idx_d   = idx_q + ID_W'(1);
                state_d = S_ISSUE;
            end
        end
    end

    // State, datapath and registered status flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= S_IDLE;
            idx_q          <= '0;
            tmr_q          <= '0;
            code_q         <= '0;
            yes_q          <= '0;
            no_q           <= '0;
            sp_q           <= '0;
            ab_q           <= '0;
            ballot_valid_q <= 1'b0;
            vote_ready_q   <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            tmr_q          <= tmr_d;
            code_q         <= code_d;
            yes_q          <= yes_d;
            no_q           <= no_d;
            sp_q           <= sp_d;
            ab_q           <= ab_d;
            ballot_valid_q <= (state_d == S_ISSUE);
            vote_ready_q   <= (state_d == S_WAIT);
            busy_q         <= (state_d == S_ISSUE) || (state_d == S_WAIT);
            done_q         <= (state_d == S_DONE);
        end
    end

    assign io_ballot_valid  = ballot_valid_q;
    assign io_vote_ready    = vote_ready_q;
    assign io_busy          = busy_q;
    assign io_done          = done_q;
    assign io_ballot_id     = idx_q;
    assign io_ballot_data   = code_q;
    assign io_yes_count     = yes_q;
    assign io_no_count      = no_q;
    assign io_spoiled_count = sp_q;
    assign io_abstain_count = ab_q;

endmodule

// File: doc/ballot_poller.md
BALLOT_POLLER -- requirements
Module: ballot_poller

Interface
REQ-001 Parameter NUM_VOTERS, default 4: number of voters polled per election (2..16).
REQ-002 Parameter CNT_W, default 8: width of each tally counter.
REQ-003 Parameter TIMEOUT, default 8: cycles in WAIT with no vote before the voter is recorded as abstaining (>=2).
REQ-004 clock  in  1  single clock; all state changes on its rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 io_start  in  1  begin an election; honoured only in IDLE or DONE.
REQ-007 io_ballot_code  in  2  ballot code; captured on an accepted start.
REQ-008 io_ballot_valid  out  1  ballot offered to voter io_ballot_id.
REQ-009 io_ballot_ready  in  1  addressed voter accepts the ballot.
REQ-010 io_ballot_id  out  clog2(NUM_VOTERS)  index of the voter currently polled.
REQ-011 io_ballot_data  out  2  captured ballot code.
REQ-012 io_vote_valid  in  1  voter response present.
REQ-013 io_vote_data  in  2  response: 1 = yes, 0 = no, 2/3 = spoiled.
REQ-014 io_vote_ready  out  1  poller accepts a response.
REQ-015 io_busy  out  1  high in ISSUE or WAIT.
REQ-016 io_done  out  1  high in DONE.
REQ-017 io_yes_count, io_no_count, io_spoiled_count, io_abstain_count  out  CNT_W each  tallies.

Function
REQ-018 FSM states: IDLE, ISSUE, WAIT, DONE.
REQ-019 IDLE/DONE + io_start: next state ISSUE; index = 0; all four tallies = 0; ballot code captured.
REQ-020 io_ballot_valid = 1 only in ISSUE; io_vote_ready = 1 only in WAIT; io_ballot_data constant during an election.
REQ-021 ISSUE: ballot_valid and ballot_ready both high -> WAIT with wait timer = 0; otherwise stay in ISSUE with index and data stable (no timeout in ISSUE).
REQ-022 WAIT, io_vote_valid = 1: increment the tally selected by io_vote_data; then advance.
REQ-023 WAIT, no vote, timer = TIMEOUT-1: increment abstain; then advance. Otherwise the timer increments.
REQ-024 Vote and timeout in the same cycle: the vote is counted and abstain is not incremented.
REQ-025 Advance: index < NUM_VOTERS-1 -> index+1, go to ISSUE; index = NUM_VOTERS-1 -> DONE.
REQ-026 DONE: tallies and io_done held until the next accepted start; io_start in DONE behaves as in IDLE (tallies cleared on the same edge).
REQ-027 io_start ignored in ISSUE and WAIT.
REQ-028 Tallies saturate at 2^CNT_W-1; they never wrap.
REQ-029 Latency: start accepted at edge t gives ballot_valid high in cycle t+1; a vote accepted at edge t shows in the tally output in cycle t+1.
REQ-030 The sum of the four tallies in DONE equals NUM_VOTERS when no tally has saturated.
REQ-031 io_vote_valid outside WAIT is ignored and changes no state.

Reset
REQ-032 With reset high at a clock edge: state IDLE, index 0, timer 0, captured code 0, all tallies 0.
REQ-033 After reset: io_ballot_valid, io_vote_ready, io_busy and io_done are 0; io_ballot_id = 0; io_ballot_data = 0.
REQ-034 Reset during ISSUE or WAIT abandons the election; no partial tallies remain.

Verification (NUM_VOTERS=4, TIMEOUT=8, CNT_W=8)
REQ-035 Stimulus: start, code=2; voters answer 1,1,0,3, each one cycle after ballot accept. Response: done with yes=2, no=1, spoiled=1, abstain=0; ballot_data=2 throughout.
REQ-036 Stimulus: start; voter 1 never answers. Response: exactly 8 WAIT cycles for id 1; abstain=1; voter 2 is then polled.
REQ-037 Stimulus: vote_valid asserted in the 8th WAIT cycle (timer=7). Response: vote counted, abstain unchanged.
REQ-038 Stimulus: ballot_ready held low 20 cycles for id 0. Response: stays in ISSUE, id 0, no abstain.
REQ-039 Stimulus: start pulses during WAIT, then reset asserted mid-WAIT. Response: start ignored; after reset all outputs at reset values; a new start begins at id 0 with zero tallies.
REQ-040 Stimulus: start in DONE after a completed election. Response: tallies zero in the next cycle; ballot_valid high with id 0.
